// File: rtl/list_pkg.sv
// Shared types for the list statistics collector: pointer type, output record and saturating helpers.
package list_pkg;

  localparam int unsigned n     = 16;
  localparam int unsigned Width = $clog2(n);

  typedef logic [Width-1:0] Pointer;

  typedef struct packed {
    Pointer             first;
    logic [Width:0]     len;
    logic [2*Width-1:0] sum;
  } list_rec_t;

  typedef enum logic {
    AccIdle,
    AccActive
  } acc_state_e;

  function automatic logic [Width:0] len_inc(input logic [Width:0] l);
    return (l == '1) ? l : l + 1'b1;
  endfunction

  // Extra carry bit detects wrap so the sum clamps to all-ones on a cyclic table.
  function automatic logic [2*Width-1:0] sum_add(input logic [2*Width-1:0] s, input Pointer p);
    logic [2*Width:0] t;
    t = {1'b0, s} + {{(Width+1){1'b0}}, p};
    return t[2*Width] ? '1 : t[2*Width-1:0];
  endfunction

endpackage

// File: rtl/rec_fifo.sv
// Synchronous record FIFO with wrapping read/write pointers and an occupancy count.
module rec_fifo
  import list_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  list_rec_t wdata,
  output list_rec_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  list_rec_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/list_stats_collector.sv
// Snoops the init sweep into a shadow next-table, accumulates {first,len,sum} per list in the
// pointer stream and queues one record per completed list; drops (and flags) when the queue is full.
module list_stats_collector
  import list_pkg::*;
#(
  parameter int unsigned N          = n,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_vld,
  input  logic [Width-1:0]     init_ptr,
  input  logic [Width-1:0]     init_ptr_next,
  input  logic [Width-1:0]     in_ptr,
  input  logic                 in_vld,
  output logic [Width-1:0]     out_first,
  output logic [Width:0]       out_len,
  output logic [2*Width-1:0]   out_sum,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 overflow,
  output logic                 err_proto
);

  Pointer             tbl_q [N];
  Pointer             nxt;
  acc_state_e         state_q, state_d;
  Pointer             first_q, first_d;
  logic [Width:0]     len_q, len_d;
  logic [2*Width-1:0] sum_q, sum_d;
  logic               overflow_q, err_proto_q;
  logic               accept, rec_push, pop;
  logic               fifo_full, fifo_empty;
  list_rec_t          rec_in, rec_out;

  always_ff @(posedge clk) begin
    if (init_vld) tbl_q[init_ptr] <= init_ptr_next;
  end

  assign nxt    = tbl_q[in_ptr];
  assign accept = in_vld & (in_ptr != '0);
  assign pop    = out_vld & out_rdy;

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    len_d    = len_q;
    sum_d    = sum_q;
    rec_push = 1'b0;
    if (accept) begin
      if (state_q == AccIdle) begin
        first_d = in_ptr;
        len_d   = (Width+1)'(1);
        sum_d   = (2*Width)'(in_ptr);
      end else begin
        len_d = len_inc(len_q);
        sum_d = sum_add(sum_q, in_ptr);
      end
      rec_push = (nxt == '0);
      state_d  = rec_push ? AccIdle : AccActive;
    end
  end

  assign rec_in = '{first: first_d, len: len_d, sum: sum_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= AccIdle;
      first_q     <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      overflow_q  <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      overflow_q  <= overflow_q | (rec_push & fifo_full & ~pop);
      err_proto_q <= err_proto_q | (in_vld & (in_ptr == '0));
    end
  end

  rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rec_push),
    .pop   (pop),
    .wdata (rec_in),
    .rdata (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_vld   = ~fifo_empty;
  assign out_first = rec_out.first;
  assign out_len   = rec_out.len;
  assign out_sum   = rec_out.sum;
  assign overflow  = overflow_q;
  assign err_proto = err_proto_q;

endmodule

// File: tb/tb_list_stats_collector.sv
// Randomized bench for list_stats_collector against a list-level reference model.
module tb_list_stats_collector;
  import list_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LEN_MAX = (1 << (Width + 1)) - 1;
  localparam int unsigned SUM_MAX = (1 << (2 * Width)) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                init_vld, in_vld, out_rdy;
  logic [Width-1:0]    init_ptr, init_ptr_next, in_ptr;
  logic [Width-1:0]    out_first;
  logic [Width:0]      out_len;
  logic [2*Width-1:0]  out_sum;
  logic                out_vld, overflow, err_proto;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  list_stats_collector #(
    .N          (n),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .init_vld      (init_vld),
    .init_ptr      (init_ptr),
    .init_ptr_next (init_ptr_next),
    .in_ptr        (in_ptr),
    .in_vld        (in_vld),
    .out_first     (out_first),
    .out_len       (out_len),
    .out_sum       (out_sum),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .overflow      (overflow),
    .err_proto     (err_proto)
  );

  // Reference state: table copy, expected record queue, sticky flags, open list totals.
  int unsigned m_tbl [n];
  int unsigned fix_tbl [n];
  list_rec_t   m_q[$];
  bit          m_ovf, m_err, m_active;
  int unsigned m_first, m_len, m_sum;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_vld", out_vld, m_q.size() > 0);
    if (m_q.size() > 0) check_eq("out_rec", {out_first, out_len, out_sum}, m_q[0]);
    check_eq("overflow", overflow, m_ovf);
    check_eq("err_proto", err_proto, m_err);
  endtask

  function automatic bit pick_rdy(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input bit iv, input int unsigned ip, input bit wv,
                      input int unsigned wp, input int unsigned wn, input bit rdy);
    list_rec_t rec;
    in_vld = iv; in_ptr = Pointer'(ip);
    init_vld = wv; init_ptr = Pointer'(wp); init_ptr_next = Pointer'(wn);
    out_rdy = rdy;
    @(negedge clk);
    check_outputs();
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (iv) begin
      if (ip == 0) m_err = 1'b1;
      else begin
        if (!m_active) begin m_first = ip; m_len = 1; m_sum = ip; end
        else begin m_len++; m_sum += ip; end
        if (m_tbl[ip] == 0) begin
          m_active  = 1'b0;
          rec.first = Pointer'(m_first);
          rec.len   = (Width+1)'((m_len > LEN_MAX) ? LEN_MAX : m_len);
          rec.sum   = (2*Width)'((m_sum > SUM_MAX) ? SUM_MAX : m_sum);
          if (m_q.size() < DEPTH) m_q.push_back(rec);
          else m_ovf = 1'b1;
        end else m_active = 1'b1;
      end
    end
    if (wv) m_tbl[wp] = wn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned cycles, input int mode);
    for (int unsigned i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, pick_rdy(mode));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 0; init_vld = 0; out_rdy = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_ovf = 0; m_err = 0; m_active = 0;
  endtask

  task automatic sweep(input int unsigned tbl [n]);
    for (int unsigned p = 0; p < n; p++) step(0, 0, 1, p, tbl[p], 1'b1);
  endtask

  task automatic write_entry(input int unsigned p, input int unsigned nx);
    step(0, 0, 1, p, nx, 1'b1);
  endtask

  function automatic void walk(input int unsigned head, inout int unsigned ptrs[$]);
    int unsigned p = head;
    for (int unsigned i = 0; i < n && p != 0; i++) begin
      ptrs.push_back(p);
      p = m_tbl[p];
    end
  endfunction

  task automatic stream(input int unsigned ptrs[$], input int mode, input bit gaps);
    foreach (ptrs[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) step(0, 0, 0, 0, 0, pick_rdy(mode));
      if (gaps && $urandom_range(0, 15) == 0) step(1, 0, 0, 0, 0, pick_rdy(mode));
      step(1, ptrs[i], 0, 0, 0, pick_rdy(mode));
    end
  endtask

  task automatic stream_heads(input int unsigned heads[$], input int mode, input bit gaps);
    int unsigned ptrs[$];
    foreach (heads[i]) walk(heads[i], ptrs);
    stream(ptrs, mode, gaps);
  endtask

  initial begin
    int unsigned perm[$];
    int unsigned heads[$];
    int unsigned rtbl [n];
    int unsigned tmp, j;

    fix_tbl = '{default: 0};
    fix_tbl[1] = 5; fix_tbl[5] = 3; fix_tbl[3] = 10;
    fix_tbl[2] = 4;
    fix_tbl[7] = 15; fix_tbl[15] = 8;
    fix_tbl[9] = 14; fix_tbl[14] = 11; fix_tbl[11] = 13; fix_tbl[13] = 12;
    m_tbl = '{default: 0};

    rst = 1'b1; in_vld = 0; in_ptr = '0; init_vld = 0; init_ptr = '0; init_ptr_next = '0; out_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check_eq("rst_out_vld", out_vld, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_err_proto", err_proto, 1'b0);
    @(posedge clk);
    #1;

    sweep(fix_tbl);
    // Single list, consumer always ready.
    stream_heads('{7}, 1, 0);
    idle(3, 1);
    // Back-to-back lists.
    stream_heads('{7, 6, 2}, 1, 0);
    idle(3, 1);
    // FIFO fills, fifth record dropped, then drain.
    stream_heads('{7, 6, 2, 1, 9}, 2, 0);
    check_eq("t3_overflow", overflow, 1'b1);
    idle(DEPTH + 2, 1);
    // Full FIFO with a pop coinciding with the last element.
    do_reset();
    stream_heads('{7, 6, 2, 1}, 2, 0);
    stream('{9, 14, 11, 13}, 2, 0);
    stream('{12}, 1, 0);
    check_eq("t4_overflow", overflow, 1'b0);
    idle(DEPTH + 2, 1);
    // Reset mid-list discards the partial list.
    stream('{9, 14}, 1, 0);
    do_reset();
    stream_heads('{6}, 1, 0);
    idle(3, 1);
    // Null pointer in the middle of a list.
    stream('{1, 5, 0, 3, 10}, 1, 0);
    idle(3, 1);
    check_eq("t6_err_proto", err_proto, 1'b1);

    // Cyclic table: len and sum must clamp.
    do_reset();
    write_entry(1, 2);
    write_entry(2, 1);
    for (int unsigned i = 0; i < 100; i++) stream('{1, 2}, 1, 0);
    write_entry(2, 0);
    stream('{2}, 1, 0);
    idle(3, 1);

    // Random tables, random order, gaps, null pointers and random backpressure.
    for (int unsigned round = 0; round < 8; round++) begin
      if ($urandom_range(0, 2) == 0) do_reset();
      perm.delete();
      for (int unsigned p = 1; p < n; p++) perm.push_back(p);
      for (int unsigned i = perm.size() - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      rtbl = '{default: 0};
      heads.delete();
      heads.push_back(perm[0]);
      for (int unsigned i = 0; i + 1 < perm.size(); i++) begin
        if ($urandom_range(0, 2) == 0) heads.push_back(perm[i + 1]);
        else rtbl[perm[i]] = perm[i + 1];
      end
      sweep(rtbl);
      for (int unsigned k = 0; k < 3; k++) begin
        for (int unsigned i = heads.size() - 1; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = heads[i]; heads[i] = heads[j]; heads[j] = tmp;
        end
        stream_heads(heads, 0, 1);
        idle($urandom_range(0, 4), 0);
      end
      idle(DEPTH + 2, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
